// File: rtl/instruction_fetch.sv
// Three-state instruction fetcher: FETCH drives a one-cycle read strobe after an address setup cycle,
// WAIT captures the returned word, READY presents it until an increment or jump starts the next fetch.
module instruction_fetch #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        program_counter_increment,
  input  logic        jump_load,
  input  logic [15:0] jump_target,
  input  logic        halt,
  output logic        mem_read,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  output logic [15:0] current_instruction,
  output logic        instruction_valid,
  output logic [15:0] program_counter
);

  typedef enum logic [1:0] {FETCH, WAIT, READY} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        mem_read_q, mem_read_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_VECTOR;
      mem_read_q <= 1'b0;
      mem_addr_q <= RESET_VECTOR;
      instr_q    <= 16'h0000;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_read_d = 1'b0;
    mem_addr_d = mem_addr_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    case (state_q)
      // mem_read_q doubles as the FETCH sub-phase: low = address setup, high = strobe issued.
      FETCH: begin
        if (!mem_read_q) begin
          mem_read_d = 1'b1;
          mem_addr_d = pc_q;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (jump_load) begin
          pc_d    = jump_target;
          state_d = FETCH;
        end else begin
          instr_d = mem_rdata;
          valid_d = 1'b1;
          state_d = READY;
        end
      end
      READY: begin
        if (!halt) begin
          if (jump_load) begin
            pc_d    = jump_target;
            valid_d = 1'b0;
            state_d = FETCH;
          end else if (program_counter_increment) begin
            pc_d    = pc_q + 16'd1;
            valid_d = 1'b0;
            state_d = FETCH;
          end
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign mem_read            = mem_read_q;
  assign mem_addr            = mem_addr_q;
  assign current_instruction = instr_q;
  assign instruction_valid   = valid_q;
  assign program_counter     = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a one-cycle-latency instruction memory model.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        incr;
  logic        jump_load;
  logic [15:0] jump_target;
  logic        halt;
  logic        mem_read;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] cur;
  logic        valid;
  logic [15:0] pc;

  int total = 0;
  int bad   = 0;

  instruction_fetch #(.RESET_VECTOR(16'h0000)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .program_counter_increment (incr),
    .jump_load                 (jump_load),
    .jump_target               (jump_target),
    .halt                      (halt),
    .mem_read                  (mem_read),
    .mem_addr                  (mem_addr),
    .mem_rdata                 (mem_rdata),
    .current_instruction       (cur),
    .instruction_valid         (valid),
    .program_counter           (pc)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'hE066;
    if (a == 16'h0001) return 16'hE027;
    return a ^ 16'hA5A5;
  endfunction

  // Read data is valid only in the cycle after the strobe; junk otherwise.
  always @(posedge clock) mem_rdata <= mem_read ? mem_word(mem_addr) : 16'hBAD0;

  task automatic test_reset();
    reset = 1'b1; incr = 1'b1; jump_load = 1'b1; jump_target = 16'h1234; halt = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (pc !== 16'h0000) begin bad++; $display("FAIL reset_pc: got %h want 0000", pc); end
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
    total++; if (mem_addr !== 16'h0000) begin bad++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
    total++; if (cur !== 16'h0000) begin bad++; $display("FAIL reset_instr: got %h want 0000", cur); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    reset = 1'b0; incr = 1'b0; jump_load = 1'b0;
    @(negedge clock);
    total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL first_read: got %b want 1", mem_read); end
    total++; if (mem_addr !== 16'h0000) begin bad++; $display("FAIL first_addr: got %h want 0000", mem_addr); end
    @(negedge clock);
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL first_wait_read: got %b want 0", mem_read); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL first_wait_valid: got %b want 0", valid); end
    @(negedge clock);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL first_valid: got %b want 1", valid); end
    total++; if (cur !== 16'hE066) begin bad++; $display("FAIL first_instr: got %h want e066", cur); end
    total++; if (pc !== 16'h0000) begin bad++; $display("FAIL first_pc: got %h want 0000", pc); end
  endtask

  task automatic test_increment();
    incr = 1'b1;
    @(negedge clock);
    incr = 1'b0;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL inc_valid1: got %b want 0", valid); end
    total++; if (pc !== 16'h0001) begin bad++; $display("FAIL inc_pc: got %h want 0001", pc); end
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL inc_setup_read: got %b want 0", mem_read); end
    @(negedge clock);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL inc_valid2: got %b want 0", valid); end
    total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL inc_read: got %b want 1", mem_read); end
    total++; if (mem_addr !== 16'h0001) begin bad++; $display("FAIL inc_addr: got %h want 0001", mem_addr); end
    @(negedge clock);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL inc_valid3: got %b want 0", valid); end
    @(negedge clock);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL inc_valid4: got %b want 1", valid); end
    total++; if (cur !== 16'hE027) begin bad++; $display("FAIL inc_instr: got %h want e027", cur); end
    total++; if (pc !== 16'h0001) begin bad++; $display("FAIL inc_pc_final: got %h want 0001", pc); end
  endtask

  task automatic test_jump_priority();
    jump_load = 1'b1; incr = 1'b1; jump_target = 16'h0040;
    @(negedge clock);
    jump_load = 1'b0; incr = 1'b0;
    total++; if (pc !== 16'h0040) begin bad++; $display("FAIL prio_pc: got %h want 0040", pc); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL prio_valid: got %b want 0", valid); end
    @(negedge clock);
    total++; if (mem_addr !== 16'h0040) begin bad++; $display("FAIL prio_addr: got %h want 0040", mem_addr); end
    total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL prio_read: got %b want 1", mem_read); end
    repeat (2) @(negedge clock);
    total++; if (cur !== 16'hA5E5) begin bad++; $display("FAIL prio_instr: got %h want a5e5", cur); end
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL prio_valid_end: got %b want 1", valid); end
  endtask

  task automatic test_jump_in_wait();
    incr = 1'b1;
    @(negedge clock);
    // Jump and increment during the issue cycle of FETCH must both be ignored.
    jump_load = 1'b1; jump_target = 16'h0777;
    @(negedge clock);
    total++; if (mem_addr !== 16'h0041) begin bad++; $display("FAIL fetch_jump_addr: got %h want 0041", mem_addr); end
    total++; if (pc !== 16'h0041) begin bad++; $display("FAIL fetch_jump_pc: got %h want 0041", pc); end
    jump_load = 1'b0;
    @(negedge clock);
    total++; if (pc !== 16'h0041) begin bad++; $display("FAIL fetch_inc_pc: got %h want 0041", pc); end
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL wait_read: got %b want 0", mem_read); end
    incr = 1'b0; jump_load = 1'b1; jump_target = 16'h0010;
    @(negedge clock);
    jump_load = 1'b0;
    total++; if (pc !== 16'h0010) begin bad++; $display("FAIL abort_pc: got %h want 0010", pc); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b want 0", valid); end
    total++; if (cur !== 16'hA5E5) begin bad++; $display("FAIL abort_instr: got %h want a5e5", cur); end
    @(negedge clock);
    total++; if (mem_addr !== 16'h0010) begin bad++; $display("FAIL abort_addr: got %h want 0010", mem_addr); end
    total++; if (cur !== 16'hA5E5) begin bad++; $display("FAIL abort_instr2: got %h want a5e5", cur); end
    repeat (2) @(negedge clock);
    total++; if (cur !== 16'hA5B5) begin bad++; $display("FAIL abort_final_instr: got %h want a5b5", cur); end
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL abort_final_valid: got %b want 1", valid); end
  endtask

  task automatic test_halt();
    halt = 1'b1; jump_target = 16'h0500;
    for (int i = 0; i < 4; i++) begin
      incr = (i % 2 == 0);
      jump_load = (i == 3);
      @(negedge clock);
      total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL halt_read[%0d]: got %b want 0", i, mem_read); end
      total++; if (pc !== 16'h0010) begin bad++; $display("FAIL halt_pc[%0d]: got %h want 0010", i, pc); end
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL halt_valid[%0d]: got %b want 1", i, valid); end
      total++; if (cur !== 16'hA5B5) begin bad++; $display("FAIL halt_instr[%0d]: got %h want a5b5", i, cur); end
    end
    incr = 1'b0; jump_load = 1'b0; halt = 1'b0;
    repeat (2) @(negedge clock);
    total++; if (pc !== 16'h0010) begin bad++; $display("FAIL halt_not_queued_pc: got %h want 0010", pc); end
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL halt_not_queued_read: got %b want 0", mem_read); end
    incr = 1'b1;
    @(negedge clock);
    incr = 1'b0; halt = 1'b1;
    total++; if (pc !== 16'h0011) begin bad++; $display("FAIL resume_pc: got %h want 0011", pc); end
    @(negedge clock);
    total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL resume_read: got %b want 1", mem_read); end
    total++; if (mem_addr !== 16'h0011) begin bad++; $display("FAIL resume_addr: got %h want 0011", mem_addr); end
    repeat (2) @(negedge clock);
    total++; if (cur !== 16'hA5B4) begin bad++; $display("FAIL halted_fetch_instr: got %h want a5b4", cur); end
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL halted_fetch_valid: got %b want 1", valid); end
    incr = 1'b1;
    repeat (2) @(negedge clock);
    total++; if (pc !== 16'h0011) begin bad++; $display("FAIL halted_hold_pc: got %h want 0011", pc); end
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL halted_hold_valid: got %b want 1", valid); end
    incr = 1'b0; halt = 1'b0;
  endtask

  task automatic test_wrap_and_reset();
    jump_load = 1'b1; jump_target = 16'hFFFF;
    @(negedge clock);
    jump_load = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (cur !== 16'h5A5A) begin bad++; $display("FAIL top_instr: got %h want 5a5a", cur); end
    total++; if (pc !== 16'hFFFF) begin bad++; $display("FAIL top_pc: got %h want ffff", pc); end
    incr = 1'b1;
    @(negedge clock);
    incr = 1'b0;
    total++; if (pc !== 16'h0000) begin bad++; $display("FAIL wrap_pc: got %h want 0000", pc); end
    @(negedge clock);
    total++; if (mem_addr !== 16'h0000) begin bad++; $display("FAIL wrap_addr: got %h want 0000", mem_addr); end
    repeat (2) @(negedge clock);
    total++; if (cur !== 16'hE066) begin bad++; $display("FAIL wrap_instr: got %h want e066", cur); end
    incr = 1'b1;
    @(negedge clock);
    incr = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %b want 0", valid); end
    total++; if (pc !== 16'h0000) begin bad++; $display("FAIL midreset_pc: got %h want 0000", pc); end
    total++; if (cur !== 16'h0000) begin bad++; $display("FAIL midreset_instr: got %h want 0000", cur); end
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL midreset_read: got %b want 0", mem_read); end
    reset = 1'b0;
    @(negedge clock);
    total++; if (cur !== 16'h0000) begin bad++; $display("FAIL postreset_instr: got %h want 0000", cur); end
    total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL postreset_read: got %b want 1", mem_read); end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_jump_priority();
    test_jump_in_wait();
    test_halt();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
